// File: rtl/branch_resolve_pipe.sv
// Pipelined jump/branch resolver: stage 0 resolves, stages 1..LAT-1 delay.
// Optional macro BRU_TARGET_CHECK_EN adds target checking on taken branches.
module branch_resolve_pipe #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int IMM_W  = 16,
    parameter int TGT_W  = 26,
    parameter int TAG_W  = 7,
    parameter int LAT    = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        op_i,
    input  logic [DATA_W-1:0] data1_i,
    input  logic [DATA_W-1:0] data2_i,
    input  logic [IMM_W-1:0]  immd_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [PC_W-1:0]   predTarget_i,
    input  logic              predDir_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [TAG_W-1:0]  tag_o,
    output logic [PC_W-1:0]   result_o,
    output logic [PC_W-1:0]   nextPC_o,
    output logic              direction_o,
    output logic              mispredict_o,
    output logic [7:0]        flags_o,
    output logic [CNT_W-1:0]  mispCount_o
);

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_J    = 4'd1;
    localparam logic [3:0] OP_JAL  = 4'd2;
    localparam logic [3:0] OP_JR   = 4'd3;
    localparam logic [3:0] OP_JALR = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_BNE  = 4'd6;
    localparam logic [3:0] OP_BLEZ = 4'd7;
    localparam logic [3:0] OP_BGTZ = 4'd8;
    localparam logic [3:0] OP_BLTZ = 4'd9;
    localparam logic [3:0] OP_BGEZ = 4'd10;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  res;
        logic [PC_W-1:0]  npc;
        logic             dir;
        logic             misp;
        logic [7:0]       flags;
    } pay_t;

    logic [LAT-1:0]   r_vld;
    pay_t             r_pay [LAT];
    logic [CNT_W-1:0] r_cnt;
    logic [LAT-1:0]   w_free;
    pay_t             w_s0;
    logic [PC_W-1:0]  w_sext;
    logic [PC_W-1:0]  w_fall;
    logic [PC_W-1:0]  w_taken;
    logic [PC_W-1:0]  w_jtgt;
    logic [PC_W-1:0]  w_d1pc;
    logic             w_msb;
    logic             w_d1z;
    logic             w_cdir;

    assign w_sext  = {{(PC_W-IMM_W-2){immd_i[IMM_W-1]}}, immd_i, 2'b00};
    assign w_fall  = pc_i + PC_W'(8);
    assign w_taken = w_fall + w_sext;
    assign w_jtgt  = {pc_i[PC_W-1:TGT_W+2], predTarget_i[TGT_W-1:0], 2'b00};
    assign w_d1pc  = data1_i[PC_W-1:0];
    assign w_msb   = data1_i[DATA_W-1];
    assign w_d1z   = (data1_i == '0);

    // A stage is free when empty or when everything downstream moves.
    always_comb begin
        logic f;
        w_free = '0;
        f = !r_vld[LAT-1] || ready_i;
        w_free[LAT-1] = f;
        for (int k = LAT - 2; k >= 0; k--) begin
            f = !r_vld[k] || f;
            w_free[k] = f;
        end
    end

    always_comb begin
        w_cdir = 1'b0;
        case (op_i)
            OP_BEQ:  w_cdir = (data1_i == data2_i);
            OP_BNE:  w_cdir = (data1_i != data2_i);
            OP_BLEZ: w_cdir = w_msb || w_d1z;
            OP_BGTZ: w_cdir = !w_msb && !w_d1z;
            OP_BLTZ: w_cdir = w_msb;
            OP_BGEZ: w_cdir = !w_msb;
            default: w_cdir = 1'b0;
        endcase
    end

    always_comb begin
        w_s0     = '0;
        w_s0.tag = tag_i;
        case (op_i)
            OP_NOP: begin
            end
            OP_J, OP_JAL: begin
                w_s0.npc      = w_jtgt;
                w_s0.dir      = 1'b1;
                w_s0.flags[7] = 1'b1;
                w_s0.flags[2] = 1'b1;
                if (op_i == OP_JAL) begin
                    w_s0.res      = w_fall;
                    w_s0.flags[4] = 1'b1;
                end
            end
            OP_JR, OP_JALR: begin
                w_s0.npc      = w_d1pc;
                w_s0.dir      = 1'b1;
                w_s0.misp     = (w_d1pc != predTarget_i);
                w_s0.flags[7] = 1'b1;
                w_s0.flags[2] = 1'b1;
                if (op_i == OP_JALR) begin
                    w_s0.res      = w_fall;
                    w_s0.flags[4] = 1'b1;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ: begin
                w_s0.dir      = w_cdir;
                w_s0.npc      = w_cdir ? w_taken : w_fall;
`ifdef BRU_TARGET_CHECK_EN
                w_s0.misp     = (w_cdir != predDir_i) ||
                                (w_cdir && predDir_i &&
                                 (w_taken != predTarget_i));
`else
                w_s0.misp     = (w_cdir != predDir_i);
`endif
                w_s0.flags[7] = 1'b1;
                w_s0.flags[5] = 1'b1;
                w_s0.flags[2] = 1'b1;
            end
            default: begin
                w_s0.flags[7] = 1'b1;
                w_s0.flags[1] = 1'b1;
            end
        endcase
        w_s0.flags[0] = w_s0.misp;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld <= '0;
            r_cnt <= '0;
            for (int k = 0; k < LAT; k++) r_pay[k] <= '0;
        end else begin
            if (valid_o && ready_i && mispredict_o && (r_cnt != '1))
                r_cnt <= r_cnt + 1'b1;
            if (w_free[0]) begin
                r_vld[0] <= valid_i;
                if (valid_i) r_pay[0] <= w_s0;
            end
            for (int k = 1; k < LAT; k++) begin
                if (w_free[k]) begin
                    r_vld[k] <= r_vld[k-1];
                    if (r_vld[k-1]) r_pay[k] <= r_pay[k-1];
                end
            end
            if (flush_i) r_vld <= '0;
        end
    end

    assign ready_o      = w_free[0];
    assign valid_o      = r_vld[LAT-1];
    assign tag_o        = r_pay[LAT-1].tag;
    assign result_o     = r_pay[LAT-1].res;
    assign nextPC_o     = r_pay[LAT-1].npc;
    assign direction_o  = r_pay[LAT-1].dir;
    assign mispredict_o = r_pay[LAT-1].misp;
    assign flags_o      = r_pay[LAT-1].flags;
    assign mispCount_o  = r_cnt;

endmodule
